// File: rtl/msk_rx_acq_ctrl.sv
// rtl/msk_rx_acq_ctrl.sv - MSK receive acquisition sequencer and lock supervisor
module msk_rx_acq_ctrl #(
  parameter int                WERR      = 18,
  parameter int                EW        = 24,
  parameter int                TED_THR   = 2048,
  parameter int                PD_THR    = 65536,
  parameter int                LOCK_CNT  = 64,
  parameter int                LOSS_CNT  = 16,
  parameter int                TMO_SYM   = 4096,
  parameter int                SYNC_W    = 32,
  parameter logic [SYNC_W-1:0] SYNC_WORD = 32'h1ACFFC1D
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable_i,
  input  logic signed [WERR-1:0] ek_i,
  input  logic                   ek_val_i,
  input  logic                   cfo_done_i,
  input  logic signed [EW-1:0]   pdet_err_i,
  input  logic                   pdet_err_val_i,
  input  logic                   data_i,
  input  logic                   data_val_i,
  output logic                   cfo_en_o,
  output logic                   fine_en_o,
  output logic                   lock_o,
  output logic                   frame_sync_o,
  output logic                   timeout_o,
  output logic [2:0]             state_o
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    TIM_ACQ    = 3'd1,
    CFO_COARSE = 3'd2,
    CFO_FINE   = 3'd3,
    SYNC_SRCH  = 3'd4,
    LOCKED     = 3'd5
  } state_e;

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(LOSS_CNT + 1);
  localparam int TW = $clog2(TMO_SYM + 1);
  localparam int FW = $clog2(SYNC_W + 1);

  state_e            state_q, state_d, fwd_state;
  logic [GW-1:0]     good_q, good_d, good_inc;
  logic [BW-1:0]     bad_q, bad_d, bad_inc;
  logic [TW-1:0]     tmo_q, tmo_d, tmo_inc;
  logic [FW-1:0]     fill_q, fill_d, fill_inc;
  logic [SYNC_W-1:0] sr_q, sr_d, sr_shift;
  logic              cfo_en_q, fine_en_q, lock_q, frame_sync_q, timeout_q;
  logic              cfo_en_d, fine_en_d, lock_d, frame_sync_d, timeout_d;
  logic              fwd, tmo_tick, tmo_hit, loss, searching, match_now;
  logic [WERR-1:0]   ek_abs;
  logic [EW-1:0]     pd_abs;
  logic              ek_in, pd_in, ek_bad, pd_bad;

  // Saturating magnitude: the most negative code maps to the largest positive one
  assign ek_abs = !ek_i[WERR-1] ? ek_i :
                  (ek_i == {1'b1, {(WERR-1){1'b0}}}) ? {1'b0, {(WERR-1){1'b1}}} : -ek_i;
  assign pd_abs = !pdet_err_i[EW-1] ? pdet_err_i :
                  (pdet_err_i == {1'b1, {(EW-1){1'b0}}}) ? {1'b0, {(EW-1){1'b1}}} : -pdet_err_i;
  assign ek_in  = ek_abs < WERR'(TED_THR);
  assign pd_in  = pd_abs < EW'(PD_THR);
  assign ek_bad = ek_val_i && !ek_in;
  assign pd_bad = pdet_err_val_i && !pd_in;

  assign good_inc = (good_q == GW'(LOCK_CNT)) ? good_q : good_q + GW'(1);
  assign bad_inc  = (bad_q == BW'(LOSS_CNT)) ? bad_q : bad_q + BW'(1);
  assign tmo_inc  = (tmo_q == TW'(TMO_SYM)) ? tmo_q : tmo_q + TW'(1);
  assign fill_inc = (fill_q == FW'(SYNC_W)) ? fill_q : fill_q + FW'(1);
  assign sr_shift = {sr_q[SYNC_W-2:0], data_i};

  // The fill count stops a partly filled register (leading zeros) from matching early
  assign searching = (state_q == SYNC_SRCH) || (state_q == LOCKED);
  assign match_now = searching && data_val_i && (fill_inc == FW'(SYNC_W)) && (sr_shift == SYNC_WORD);

  always_comb begin
    good_d    = good_q;
    bad_d     = bad_q;
    tmo_d     = tmo_q;
    fill_d    = fill_q;
    sr_d      = sr_q;
    fwd       = 1'b0;
    fwd_state = state_q;
    tmo_tick  = 1'b0;
    loss      = 1'b0;
    case (state_q)
      IDLE: begin
        fwd       = 1'b1;
        fwd_state = TIM_ACQ;
      end
      TIM_ACQ: begin
        tmo_tick  = ek_val_i;
        if (ek_val_i) good_d = ek_in ? good_inc : '0;
        fwd       = (good_d == GW'(LOCK_CNT));
        fwd_state = CFO_COARSE;
      end
      CFO_COARSE: begin
        tmo_tick  = ek_val_i;
        fwd       = cfo_done_i;
        fwd_state = CFO_FINE;
      end
      CFO_FINE: begin
        tmo_tick  = ek_val_i;
        if (pdet_err_val_i) good_d = pd_in ? good_inc : '0;
        fwd       = (good_d == GW'(LOCK_CNT));
        fwd_state = SYNC_SRCH;
      end
      SYNC_SRCH: begin
        tmo_tick  = data_val_i;
        fwd       = match_now;
        fwd_state = LOCKED;
      end
      LOCKED: begin
        if (ek_bad || pd_bad) bad_d = bad_inc;
        else if (ek_val_i || pdet_err_val_i) bad_d = '0;
        loss = (bad_d == BW'(LOSS_CNT));
      end
      default: begin
        fwd       = 1'b1;
        fwd_state = IDLE;
      end
    endcase

    if (tmo_tick) tmo_d = tmo_inc;
    tmo_hit = (tmo_d == TW'(TMO_SYM));

    state_d = state_q;
    if (tmo_hit || loss) state_d = IDLE;
    else if (fwd)        state_d = fwd_state;
    if (!enable_i)       state_d = IDLE;

    if (state_d != state_q) begin
      good_d = '0;
      bad_d  = '0;
      tmo_d  = '0;
    end

    if (searching && data_val_i) begin
      sr_d   = sr_shift;
      fill_d = fill_inc;
    end
    if (!(state_d == SYNC_SRCH || state_d == LOCKED) ||
        (state_d == SYNC_SRCH && state_q != SYNC_SRCH)) begin
      sr_d   = '0;
      fill_d = '0;
    end

    cfo_en_d     = (state_d == CFO_COARSE) || (state_d == CFO_FINE) ||
                   (state_d == SYNC_SRCH) || (state_d == LOCKED);
    fine_en_d    = (state_d == CFO_FINE) || (state_d == SYNC_SRCH) || (state_d == LOCKED);
    lock_d       = (state_d == LOCKED);
    frame_sync_d = match_now && (state_d == LOCKED);
    timeout_d    = tmo_hit && enable_i;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      good_q       <= '0;
      bad_q        <= '0;
      tmo_q        <= '0;
      fill_q       <= '0;
      sr_q         <= '0;
      cfo_en_q     <= 1'b0;
      fine_en_q    <= 1'b0;
      lock_q       <= 1'b0;
      frame_sync_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      good_q       <= good_d;
      bad_q        <= bad_d;
      tmo_q        <= tmo_d;
      fill_q       <= fill_d;
      sr_q         <= sr_d;
      cfo_en_q     <= cfo_en_d;
      fine_en_q    <= fine_en_d;
      lock_q       <= lock_d;
      frame_sync_q <= frame_sync_d;
      timeout_q    <= timeout_d;
    end
  end

  assign cfo_en_o     = cfo_en_q;
  assign fine_en_o    = fine_en_q;
  assign lock_o       = lock_q;
  assign frame_sync_o = frame_sync_q;
  assign timeout_o    = timeout_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_msk_rx_acq_ctrl.sv
// tb/tb_msk_rx_acq_ctrl.sv - self-checking bench for msk_rx_acq_ctrl
module tb_msk_rx_acq_ctrl;

  localparam int WERR = 18;
  localparam int EW = 24;
  localparam int TED_THR = 2048;
  localparam int PD_THR = 65536;
  localparam int LOCK_CNT = 64;
  localparam int LOSS_CNT = 16;
  localparam int TMO_SYM = 4096;
  localparam logic [31:0] SYNC = 32'h1ACFFC1D;

  logic clk, reset_n, enable, ek_val, cfo_done, pd_val, data_bit, data_val;
  logic signed [WERR-1:0] ek;
  logic signed [EW-1:0] pd;
  logic cfo_en, fine_en, lock, fs, to;
  logic [2:0] st;

  msk_rx_acq_ctrl dut (
    .clk(clk), .reset_n(reset_n), .enable_i(enable),
    .ek_i(ek), .ek_val_i(ek_val), .cfo_done_i(cfo_done),
    .pdet_err_i(pd), .pdet_err_val_i(pd_val),
    .data_i(data_bit), .data_val_i(data_val),
    .cfo_en_o(cfo_en), .fine_en_o(fine_en), .lock_o(lock),
    .frame_sync_o(fs), .timeout_o(to), .state_o(st)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Reference model: stage number, counts of strobes, and a history of received bits
  int m_state, m_good, m_bad, m_tmo, m_seen;
  bit m_hist[$];
  bit e_fs, e_to;

  function automatic int sat_abs(input int v, input int w);
    int mn;
    mn = -(1 << (w - 1));
    if (v == mn) return -mn - 1;
    return (v < 0) ? -v : v;
  endfunction

  task automatic model_reset();
    m_state = 0; m_good = 0; m_bad = 0; m_tmo = 0; m_seen = 0;
    m_hist.delete();
    e_fs = 0; e_to = 0;
  endtask

  task automatic m_go(input int s);
    if (s != m_state) begin
      m_good = 0; m_bad = 0; m_tmo = 0;
      if (s == 4) begin
        m_hist.delete();
        m_seen = 0;
      end
    end
    m_state = s;
  endtask

  task automatic model_step();
    bit ek_ok, pd_ok, match, any_bad;
    logic [31:0] last;
    ek_ok = sat_abs(int'(ek), WERR) < TED_THR;
    pd_ok = sat_abs(int'(pd), EW) < PD_THR;
    e_fs = 0; e_to = 0; match = 0;
    if (enable && (m_state == 4 || m_state == 5) && data_val) begin
      m_hist.push_back(data_bit);
      if (m_hist.size() > 32) void'(m_hist.pop_front());
      m_seen++;
      last = '0;
      for (int i = 0; i < m_hist.size(); i++) last = {last[30:0], m_hist[i]};
      match = (m_seen >= 32) && (last == SYNC);
    end
    if (!enable) m_go(0);
    else case (m_state)
      0: m_go(1);
      1, 2, 3: begin
        if (ek_val) m_tmo++;
        if (m_state == 1 && ek_val) m_good = ek_ok ? m_good + 1 : 0;
        if (m_state == 3 && pd_val) m_good = pd_ok ? m_good + 1 : 0;
        if (m_tmo >= TMO_SYM) begin
          e_to = 1;
          m_go(0);
        end else if ((m_state == 2 && cfo_done) || (m_state != 2 && m_good >= LOCK_CNT))
          m_go(m_state + 1);
      end
      4: begin
        if (data_val) m_tmo++;
        if (m_tmo >= TMO_SYM) begin
          e_to = 1;
          m_go(0);
        end else if (match) begin
          e_fs = 1;
          m_go(5);
        end
      end
      5: begin
        any_bad = (ek_val && !ek_ok) || (pd_val && !pd_ok);
        if (any_bad) m_bad++;
        else if (ek_val || pd_val) m_bad = 0;
        if (m_bad >= LOSS_CNT) m_go(0);
        else e_fs = match;
      end
      default: m_go(0);
    endcase
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic chk_model();
    chk("m_state", int'(st), m_state);
    chk("m_cfo_en", int'(cfo_en), int'(m_state >= 2 && m_state <= 5));
    chk("m_fine_en", int'(fine_en), int'(m_state >= 3 && m_state <= 5));
    chk("m_lock", int'(lock), int'(m_state == 5));
    chk("m_frame_sync", int'(fs), int'(e_fs));
    chk("m_timeout", int'(to), int'(e_to));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    ek_val = 0; pd_val = 0; cfo_done = 0; data_val = 0; data_bit = 0;
    ek = '0; pd = '0;
  endtask

  task automatic feed_ek(input int n, input int v);
    ek = WERR'(v); ek_val = 1;
    repeat (n) tick();
    ek_val = 0;
  endtask

  task automatic feed_pd(input int n, input int v);
    pd = EW'(v); pd_val = 1;
    repeat (n) tick();
    pd_val = 0;
  endtask

  task automatic send_bits(input logic [31:0] w, input int hi, input int lo, output int pulses);
    pulses = 0; data_val = 1;
    for (int i = hi; i >= lo; i--) begin
      data_bit = w[i];
      tick();
      if (fs) pulses++;
    end
    data_val = 0;
  endtask

  task automatic restart();
    quiet();
    enable = 0; tick();
    enable = 1; tick();
  endtask

  task automatic bring_to(input int s);
    int p;
    restart();
    if (s >= 2) feed_ek(LOCK_CNT, 100);
    if (s >= 3) begin cfo_done = 1; tick(); cfo_done = 0; end
    if (s >= 4) feed_pd(LOCK_CNT, 1000);
    if (s >= 5) send_bits(SYNC, 31, 0, p);
  endtask

  typedef struct {
    int          ek;
    logic [2:0]  exp_state;
  } vec_t;
  vec_t tbl[9];

  int p;
  bit noisy;
  bit pend[$];

  initial begin
    tbl[0] = '{100, 3'd2};
    tbl[1] = '{0, 3'd2};
    tbl[2] = '{2047, 3'd2};
    tbl[3] = '{-2047, 3'd2};
    tbl[4] = '{2048, 3'd1};
    tbl[5] = '{-2048, 3'd1};
    tbl[6] = '{-3000, 3'd1};
    tbl[7] = '{-131072, 3'd1};
    tbl[8] = '{131071, 3'd1};

    model_reset();
    reset_n = 0; enable = 0; quiet();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", int'(st), 0);
    chk("rst_cfo_en", int'(cfo_en), 0);
    chk("rst_fine_en", int'(fine_en), 0);
    chk("rst_lock", int'(lock), 0);
    chk("rst_frame_sync", int'(fs), 0);
    chk("rst_timeout", int'(to), 0);
    reset_n = 1;

    // Timing acquisition completes exactly on the 64th good strobe
    enable = 1; tick();
    chk("idle_to_tim", int'(st), 1);
    feed_ek(LOCK_CNT - 1, 100);
    chk("tim_63_state", int'(st), 1);
    chk("tim_63_cfo_en", int'(cfo_en), 0);
    feed_ek(1, 100);
    chk("tim_64_state", int'(st), 2);
    chk("tim_64_cfo_en", int'(cfo_en), 1);

    // Threshold boundaries: 63 good samples, then the table value decides
    for (int i = 0; i < 9; i++) begin
      restart();
      feed_ek(LOCK_CNT - 1, 100);
      feed_ek(1, tbl[i].ek);
      chk($sformatf("thr_ek_%0d", tbl[i].ek), int'(st), int'(tbl[i].exp_state));
    end
    feed_ek(LOCK_CNT - 1, 100);
    chk("restart_63", int'(st), 1);
    feed_ek(1, 100);
    chk("restart_64", int'(st), 2);

    // Full bring-up through LOCKED
    cfo_done = 1; tick(); cfo_done = 0;
    chk("coarse_to_fine", int'(st), 3);
    chk("fine_en_on", int'(fine_en), 1);
    feed_pd(LOCK_CNT - 1, 1000);
    chk("fine_63", int'(st), 3);
    feed_pd(1, 1000);
    chk("fine_64", int'(st), 4);
    send_bits(32'h000000A5, 7, 0, p);
    send_bits(SYNC, 31, 0, p);
    chk("sync_pulses", p, 1);
    chk("sync_fs_last", int'(fs), 1);
    chk("sync_locked", int'(st), 5);
    chk("sync_lock", int'(lock), 1);
    tick();
    chk("sync_fs_single", int'(fs), 0);
    send_bits(SYNC, 31, 0, p);
    chk("locked_resync_pulses", p, 1);
    chk("locked_stays", int'(st), 5);

    // Loss of lock
    feed_pd(LOSS_CNT - 1, 200000);
    chk("loss_15_state", int'(st), 5);
    feed_pd(1, 200000);
    chk("loss_16_state", int'(st), 0);
    chk("loss_lock", int'(lock), 0);
    chk("loss_fine_en", int'(fine_en), 0);
    chk("loss_cfo_en", int'(cfo_en), 0);
    tick();
    chk("loss_reacq", int'(st), 1);

    // Timeout in CFO_COARSE
    bring_to(2);
    feed_ek(TMO_SYM - 1, 100);
    chk("tmo_4095_state", int'(st), 2);
    chk("tmo_4095_to", int'(to), 0);
    feed_ek(1, 100);
    chk("tmo_state", int'(st), 0);
    chk("tmo_pulse", int'(to), 1);
    tick();
    chk("tmo_reacq", int'(st), 1);
    chk("tmo_pulse_end", int'(to), 0);

    // enable low mid CFO_FINE
    bring_to(3);
    feed_pd(10, 1000);
    enable = 0; tick();
    chk("en_low_state", int'(st), 0);
    chk("en_low_cfo", int'(cfo_en), 0);
    chk("en_low_fine", int'(fine_en), 0);
    enable = 1; tick();
    chk("en_high_again", int'(st), 1);

    // Async reset mid SYNC_SRCH, then no spurious match from stale bits
    bring_to(4);
    send_bits(SYNC, 31, 12, p);
    chk("partial_no_pulse", p, 0);
    reset_n = 0;
    #1;
    chk("arst_state", int'(st), 0);
    chk("arst_cfo", int'(cfo_en), 0);
    chk("arst_fine", int'(fine_en), 0);
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1;
    bring_to(4);
    send_bits(SYNC, 11, 0, p);
    chk("post_rst_no_pulse", p, 0);
    chk("post_rst_state", int'(st), 4);
    send_bits(SYNC, 31, 0, p);
    chk("post_rst_match", p, 1);
    chk("post_rst_locked", int'(st), 5);

    // Randomized run against the reference model
    for (int i = 0; i < 24000; i++) begin
      noisy = (i >= 12000 && i < 20000);
      enable = ($urandom_range(0, 2999) != 0);
      ek_val = $urandom_range(0, 1);
      if ($urandom_range(0, 99) < (noisy ? 50 : 1)) begin
        case ($urandom_range(0, 4))
          0: ek = WERR'(2048);
          1: ek = WERR'(-2048);
          2: ek = WERR'(-131072);
          default: ek = WERR'($urandom);
        endcase
      end else ek = WERR'(int'($urandom_range(0, 4094)) - 2047);
      pd_val = $urandom_range(0, 1);
      if ($urandom_range(0, 99) < (noisy ? 50 : 1)) begin
        case ($urandom_range(0, 3))
          0: pd = EW'(65536);
          1: pd = EW'(-8388608);
          default: pd = EW'($urandom);
        endcase
      end else pd = EW'(int'($urandom_range(0, 131070)) - 65535);
      cfo_done = ($urandom_range(0, 39) == 0);
      data_val = $urandom_range(0, 1);
      if (data_val) begin
        if (pend.size() == 0 && $urandom_range(0, 63) == 0)
          for (int b = 31; b >= 0; b--) pend.push_back(SYNC[b]);
        data_bit = (pend.size() != 0) ? pend.pop_front() : 1'($urandom_range(0, 1));
      end
      tick();
      chk_model();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/msk_rx_acq_ctrl.md
Name: msk_rx_acq_ctrl

Overview:
- Acquisition sequencer for the MSK receive chain: brings up the symbol timing loop, coarse CFO, fine carrier loop and frame sync in order, then supervises lock.
- Watches the Gardner error, the coarse-CFO done pulse, the phase-detector error and the sliced bit stream.
- Drives the enables for the carrier-recovery stages and reports lock and frame-sync status.
- Sits beside the timing-recovery and carrier-recovery datapaths and replaces ad-hoc testbench enables.

Parameters:
- WERR, 18, Gardner error width (signed).
- EW, 24, phase-detector error width (signed).
- TED_THR, 2048, timing lock threshold on |ek|.
- PD_THR, 65536, carrier lock threshold on |pdet_err|.
- LOCK_CNT, 64, consecutive in-threshold samples required to declare a stage locked.
- LOSS_CNT, 16, consecutive out-of-threshold samples in LOCKED that declare loss of lock.
- TMO_SYM, 4096, per-state timeout in qualifying valid strobes.
- SYNC_W, 32, sync word length.
- SYNC_WORD, 32'h1ACFFC1D, sync pattern, MSB first.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- enable_i  in  1  run acquisition; low forces IDLE
- ek_i  in  WERR  Gardner timing error, signed
- ek_val_i  in  1  ek_i valid strobe
- cfo_done_i  in  1  coarse CFO estimate-done pulse
- pdet_err_i  in  EW  carrier phase error, signed
- pdet_err_val_i  in  1  pdet_err_i valid strobe
- data_i  in  1  sliced bit from the carrier-path slicer
- data_val_i  in  1  data_i valid strobe
- cfo_en_o  out  1  coarse CFO enable
- fine_en_o  out  1  derotator, phase-detector and loop-filter enable
- lock_o  out  1  full receive lock
- frame_sync_o  out  1  one-clock pulse on each sync-word match
- timeout_o  out  1  one-clock pulse when any acquisition state times out
- state_o  out  3  current state encoding

Behaviour:
- Reset values: all outputs 0; state IDLE (0); counters and shift register cleared.
- All outputs are registered.
- A state change occurs on the clock edge after the qualifying strobe.
- Outputs reflect the new state on that same edge.
- States:
  - IDLE=0
  - TIM_ACQ=1
  - CFO_COARSE=2
  - CFO_FINE=3
  - SYNC_SRCH=4
  - LOCKED=5
  - 6 and 7 are unused and return to IDLE.
- IDLE -> TIM_ACQ when enable_i=1.
- enable_i=0 in any state -> IDLE next cycle, with all counters cleared.
- Absolute value is computed at input width.
- The most negative input saturates to max positive; for example ek_i = -131072 gives |ek| = 131071.
- "In threshold" means |e| < THR (strict).
- TIM_ACQ:
  - On each ek_val_i, the good counter increments if in threshold, else clears to 0.
  - When the good counter reaches LOCK_CNT -> CFO_COARSE.
- CFO_COARSE:
  - cfo_en_o=1.
  - On cfo_done_i=1 -> CFO_FINE.
  - cfo_en_o stays high in CFO_FINE, SYNC_SRCH and LOCKED.
- CFO_FINE:
  - fine_en_o=1.
  - The same good-counter rule applies, on pdet_err_val_i against PD_THR.
  - When LOCK_CNT is reached -> SYNC_SRCH.
  - fine_en_o stays high through LOCKED.
- SYNC_SRCH:
  - The SYNC_W shift register shifts data_i in at the LSB on each data_val_i.
  - An exact match of the registered, post-shift value against SYNC_WORD -> LOCKED, with frame_sync_o pulsed 1 clock.
  - The shift register is cleared on entry, so a match cannot occur before SYNC_W valid bits.
- LOCKED:
  - lock_o=1.
  - The sync search continues; every match pulses frame_sync_o.
  - The bad counter increments on pdet_err_val_i out of threshold and clears on in-threshold.
  - The bad counter also increments on ek_val_i with |ek| >= TED_THR.
  - If both strobes fire in one cycle and either error is out of threshold, increment by 1; clear only if both are in threshold.
  - When the bad counter reaches LOSS_CNT -> IDLE; lock_o and the enables drop on that edge.
- Timeout:
  - The timeout counter clears on every state entry.
  - In TIM_ACQ, CFO_COARSE and CFO_FINE it counts ek_val_i strobes.
  - In SYNC_SRCH it counts data_val_i strobes.
  - Reaching TMO_SYM -> IDLE, with a 1-clock timeout_o pulse.
  - IDLE immediately re-enters TIM_ACQ the next cycle if enable_i is still 1.
- Priority in a single cycle, highest first: enable_i=0, then loss/timeout, then forward transition.
- A lock-count completion and a timeout in the same cycle take the timeout.
- Counters saturate at their terminal value and never wrap.
- reset_n assertion mid-operation clears everything asynchronously; operation resumes from IDLE after deassertion.

Test Plan:
- enable_i=1 with ek_i=100 on every ek_val_i -> state 1->2 exactly on the 64th strobe; cfo_en_o rises on that edge.
- In TIM_ACQ, feed 63 good ek_i, then ek_i=-3000, then 64 good -> no transition until 64 after the bad sample; ek_i=-131072 is treated as out of threshold.
- Full bring-up:
  - stimulus: cfo_done_i pulse, then 64 pdet_err=1000, then bit stream containing 0x1ACFFC1D.
  - required: states 2->3->4->5; frame_sync_o is a single pulse one clock after the last sync bit's strobe; lock_o=1.
- In LOCKED, send 16 consecutive pdet_err=200000 -> IDLE on the 16th strobe; lock_o, fine_en_o and cfo_en_o drop; then TIM_ACQ the next cycle.
- Hold in CFO_COARSE with no cfo_done_i for 4096 ek_val_i -> timeout_o pulses for 1 clock; state 0 then 1.
- Assert reset_n low mid SYNC_SRCH and enable_i low mid CFO_FINE -> all outputs 0 immediately (async) or next edge respectively; the sync shift register is cleared, so there is no spurious frame_sync_o.
